nco_phase_bank: RTL and testbench

NCO_PHASE_BANK -- requirements
Module: nco_phase_bank

---
 rtl/nco_pkg.sv | 14 +
 rtl/nco_phase_chan.sv | 60 ++++++
 rtl/nco_phase_bank.sv | 114 +++++++++++
 tb/tb_nco_phase_bank.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/nco_pkg.sv
// Shared types and default sizing for the NCO phase bank.
// The optional channel-0 sweep is built only when NCO_PHASE_BANK_SWEEP_EN is defined.
package nco_pkg;

  localparam int NCO_NCH_DEF = 4;
  localparam int NCO_PW_DEF  = 19;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_APPLY = 2'd2
  } nco_state_e;

endpackage

// File: rtl/nco_phase_chan.sv
// One phase channel: shadow/active increment and offset, accumulator, registered phase output.
module nco_phase_chan #(
  parameter int PW = 19
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          wr_i,
  input  logic [PW-1:0] inc_i,
  input  logic [PW-1:0] ofs_i,
  input  logic          apply_i,
  input  logic          clr_i,
  input  logic          sweep_i,
  input  logic [PW-1:0] step_i,
  output logic [PW-1:0] phase_o,
  output logic          carry_o
);

  logic [PW-1:0] inc_sh_q, ofs_sh_q;
  logic [PW-1:0] inc_act_q, ofs_act_q;
  logic [PW-1:0] acc_q, acc_d;
  logic [PW-1:0] inc_act_d;
  logic [PW-1:0] phase_q;

  assign {carry_o, acc_d} = {1'b0, acc_q} + {1'b0, inc_act_q};

  // A commit always wins over a sweep step in the same cycle.
  always_comb begin
    inc_act_d = inc_act_q;
    if (apply_i) begin
      inc_act_d = inc_sh_q;
    end else if (sweep_i) begin
      inc_act_d = inc_act_q + step_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      inc_sh_q  <= '0;
      ofs_sh_q  <= '0;
      inc_act_q <= '0;
      ofs_act_q <= '0;
      acc_q     <= '0;
      phase_q   <= '0;
    end else begin
      if (wr_i) begin
        inc_sh_q <= inc_i;
        ofs_sh_q <= ofs_i;
      end
      inc_act_q <= inc_act_d;
      if (apply_i) begin
        ofs_act_q <= ofs_sh_q;
      end
      acc_q   <= clr_i ? '0 : acc_d;
      phase_q <= acc_q + ofs_act_q;
    end
  end

  assign phase_o = phase_q;

endmodule

// File: rtl/nco_phase_bank.sv
// Bank of NCH phase accumulators with glitch-free shadow-to-active commit, optionally on channel-0 wrap.
// Defining NCO_PHASE_BANK_SWEEP_EN adds a linear sweep of the channel-0 increment.
module nco_phase_bank
  import nco_pkg::*;
#(
  parameter int NCH = NCO_NCH_DEF,
  parameter int PW  = NCO_PW_DEF
) (
  input  logic                                   sys_clk,
  input  logic                                   rst_n,
  input  logic                                   cfg_valid,
  output logic                                   cfg_ready,
  input  logic [((NCH > 1) ? $clog2(NCH) : 1)-1:0] cfg_ch,
  input  logic [PW-1:0]                          cfg_inc,
  input  logic [PW-1:0]                          cfg_ofs,
  input  logic                                   commit,
  input  logic                                   commit_on_wrap,
  input  logic                                   sync_clr,
  input  logic                                   sweep_en,
  input  logic [PW-1:0]                          sweep_step,
  output logic [NCH*PW-1:0]                      phase_out,
  output logic                                   commit_done,
  output logic                                   wrap0
);

  localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;

  nco_state_e     state_q;
  logic           ready_q, done_q, wrap0_q;
  logic           apply;
  logic [NCH-1:0] carry;
  logic           sweep0;
  logic [PW-1:0]  step0;
  logic           unused_carry;

  assign apply        = (state_q == ST_APPLY);
  assign unused_carry = ^carry;

`ifdef NCO_PHASE_BANK_SWEEP_EN
  assign sweep0 = sweep_en && (state_q == ST_IDLE);
  assign step0  = sweep_step;
`else
  logic unused_sweep;
  assign sweep0       = 1'b0;
  assign step0        = '0;
  assign unused_sweep = ^{sweep_en, sweep_step};
`endif

  // Commit sequencer; ARMED waits for the channel-0 carry so the switch lands on a wrap.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (commit) begin
            ready_q <= 1'b0;
            if (commit_on_wrap) begin
              state_q <= ST_ARMED;
            end else begin
              state_q <= ST_APPLY;
              done_q  <= 1'b1;
            end
          end
        end
        ST_ARMED: begin
          if (carry[0]) begin
            state_q <= ST_APPLY;
            done_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      wrap0_q <= 1'b0;
    end else begin
      wrap0_q <= carry[0];
    end
  end

  for (genvar k = 0; k < NCH; k++) begin : g_ch
    logic wr;
    assign wr = cfg_valid && ready_q && (cfg_ch == CHW'(k));

    nco_phase_chan #(.PW(PW)) u_chan (
      .clk_i   (sys_clk),
      .rst_ni  (rst_n),
      .wr_i    (wr),
      .inc_i   (cfg_inc),
      .ofs_i   (cfg_ofs),
      .apply_i (apply),
      .clr_i   (sync_clr),
      .sweep_i ((k == 0) ? sweep0 : 1'b0),
      .step_i  ((k == 0) ? step0 : {PW{1'b0}}),
      .phase_o (phase_out[k*PW +: PW]),
      .carry_o (carry[k])
    );
  end

  assign cfg_ready   = ready_q;
  assign commit_done = done_q;
  assign wrap0       = wrap0_q;

endmodule

// File: tb/tb_nco_phase_bank.sv
// Directed bench for nco_phase_bank with NCH=4, PW=19.
module tb_nco_phase_bank;

  localparam int NCH = 4;
  localparam int PW  = 19;
  localparam logic [31:0] PMASK = 32'h7FFFF;

  logic              sys_clk = 1'b0;
  logic              rst_n;
  logic              cfg_valid;
  logic              cfg_ready;
  logic [1:0]        cfg_ch;
  logic [PW-1:0]     cfg_inc, cfg_ofs;
  logic              commit, commit_on_wrap, sync_clr, sweep_en;
  logic [PW-1:0]     sweep_step;
  logic [NCH*PW-1:0] phase_out;
  logic              commit_done, wrap0;

  int n_checks = 0;
  int n_fail   = 0;

  nco_phase_bank #(.NCH(NCH), .PW(PW)) dut (
    .sys_clk        (sys_clk),
    .rst_n          (rst_n),
    .cfg_valid      (cfg_valid),
    .cfg_ready      (cfg_ready),
    .cfg_ch         (cfg_ch),
    .cfg_inc        (cfg_inc),
    .cfg_ofs        (cfg_ofs),
    .commit         (commit),
    .commit_on_wrap (commit_on_wrap),
    .sync_clr       (sync_clr),
    .sweep_en       (sweep_en),
    .sweep_step     (sweep_step),
    .phase_out      (phase_out),
    .commit_done    (commit_done),
    .wrap0          (wrap0)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ph(input int k);
    return 32'(phase_out[k*PW +: PW]);
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  task automatic cfg_write(input logic [1:0] ch, input logic [PW-1:0] inc, input logic [PW-1:0] ofs);
    cfg_valid = 1'b1;
    cfg_ch    = ch;
    cfg_inc   = inc;
    cfg_ofs   = ofs;
    cyc(1);
    cfg_valid = 1'b0;
  endtask

  task automatic do_commit(input logic on_wrap);
    commit         = 1'b1;
    commit_on_wrap = on_wrap;
    cyc(1);
    commit         = 1'b0;
    commit_on_wrap = 1'b0;
  endtask

  logic [31:0] p0, p1, d_before, d_after;

  initial begin
    rst_n = 1'b0; cfg_valid = 1'b0; cfg_ch = '0; cfg_inc = '0; cfg_ofs = '0;
    commit = 1'b0; commit_on_wrap = 1'b0; sync_clr = 1'b0;
    sweep_en = 1'b0; sweep_step = '0;

    // Reset state
    cyc(2);
    check_eq("rst_phase1", ph(1), 32'h0);
    check_eq("rst_ready", 32'(cfg_ready), 32'h1);
    check_eq("rst_done", 32'(commit_done), 32'h0);
    check_eq("rst_wrap0", 32'(wrap0), 32'h0);
    rst_n = 1'b1;
    cyc(1);

    // Immediate commit of ch1 inc=0x01000
    cfg_write(2'd1, 19'h01000, 19'h0);
    do_commit(1'b0);
    check_eq("imm_done", 32'(commit_done), 32'h1);
    check_eq("imm_ready_lo", 32'(cfg_ready), 32'h0);
    cyc(1);
    check_eq("imm_done_lo", 32'(commit_done), 32'h0);
    check_eq("imm_ready_hi", 32'(cfg_ready), 32'h1);
    cyc(1); check_eq("ch1_ph_e2", ph(1), 32'h00000);
    cyc(1); check_eq("ch1_ph_e3", ph(1), 32'h01000);
    cyc(1); check_eq("ch1_ph_e4", ph(1), 32'h02000);
    cyc(1); check_eq("ch1_ph_e5", ph(1), 32'h03000);

    // Offset wrap: ch2 ofs=0x7FFFF, inc=1
    cfg_write(2'd2, 19'h00001, 19'h7FFFF);
    do_commit(1'b0);
    cyc(2); check_eq("ch2_ph_0", ph(2), 32'h7FFFF);
    cyc(1); check_eq("ch2_ph_1", ph(2), 32'h00000);
    cyc(1); check_eq("ch2_ph_2", ph(2), 32'h00001);

    // Commit deferred to channel-0 wrap
    cfg_write(2'd0, 19'h40000, 19'h0);
    do_commit(1'b0);
    cyc(1);
    cfg_write(2'd0, 19'h20000, 19'h0);
    sync_clr = 1'b1;
    cyc(1);
    sync_clr = 1'b0;
    cyc(1);
    check_eq("wrap_pre_ready", 32'(cfg_ready), 32'h1);
    do_commit(1'b1);
    check_eq("armed_ready", 32'(cfg_ready), 32'h0);
    check_eq("armed_done", 32'(commit_done), 32'h0);
    check_eq("armed_wrap_idle", 32'(wrap0), 32'h1);
    cyc(1);
    check_eq("armed2_ready", 32'(cfg_ready), 32'h0);
    check_eq("armed2_done", 32'(commit_done), 32'h0);
    check_eq("armed2_wrap", 32'(wrap0), 32'h0);
    cyc(1);
    check_eq("apply_done", 32'(commit_done), 32'h1);
    check_eq("apply_wrap", 32'(wrap0), 32'h1);
    check_eq("apply_ready", 32'(cfg_ready), 32'h0);
    cyc(1);
    check_eq("post_ready", 32'(cfg_ready), 32'h1);
    check_eq("post_done", 32'(commit_done), 32'h0);
    cyc(2);
    check_eq("ch0_new_inc", ph(0), 32'h60000);

    // sync_clr in the APPLY cycle
    cfg_write(2'd3, 19'h00100, 19'h0);
    do_commit(1'b0);
    sync_clr = 1'b1;
    cyc(1);
    sync_clr = 1'b0;
    cyc(1);
    check_eq("clr_ph0_a", ph(0), 32'h00000);
    check_eq("clr_ph1_a", ph(1), 32'h00000);
    check_eq("clr_ph2_a", ph(2), 32'h7FFFF);
    check_eq("clr_ph3_a", ph(3), 32'h00000);
    cyc(1);
    check_eq("clr_ph0_b", ph(0), 32'h20000);
    check_eq("clr_ph1_b", ph(1), 32'h01000);
    check_eq("clr_ph2_b", ph(2), 32'h00000);
    check_eq("clr_ph3_b", ph(3), 32'h00100);

    // Channel-0 sweep (no effect unless the sweep build option is enabled)
    p0 = ph(0); cyc(1); p1 = ph(0);
    d_before = (p1 - p0) & PMASK;
    sweep_step = 19'd2;
    sweep_en   = 1'b1;
    cyc(10);
    sweep_en   = 1'b0;
    cyc(2);
    p0 = ph(0); cyc(1); p1 = ph(0);
    d_after = (p1 - p0) & PMASK;
`ifdef NCO_PHASE_BANK_SWEEP_EN
    check_eq("sweep_inc", d_after, (d_before + 32'd20) & PMASK);
`else
    check_eq("sweep_ignored", d_after, d_before);
`endif

    // Reset while ARMED
    cfg_write(2'd1, 19'h02000, 19'h0);
    do_commit(1'b1);
    check_eq("rstarm_ready_lo", 32'(cfg_ready), 32'h0);
    rst_n = 1'b0;
    #1;
    for (int k = 0; k < NCH; k++) check_eq($sformatf("rstarm_ph%0d", k), ph(k), 32'h0);
    check_eq("rstarm_ready", 32'(cfg_ready), 32'h1);
    check_eq("rstarm_done", 32'(commit_done), 32'h0);
    check_eq("rstarm_wrap", 32'(wrap0), 32'h0);
    cyc(2);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cyc(1);
      check_eq($sformatf("rstarm_nodone%0d", i), 32'(commit_done), 32'h0);
    end
    check_eq("rstarm_ph1_idle", ph(1), 32'h0);
    check_eq("rstarm_ready_end", 32'(cfg_ready), 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
